wb_addr_sequencer: RTL and testbench

WB_ADDR_SEQUENCER -- requirements
Module: wb_addr_sequencer

---
 rtl/wb_addr_sequencer_pkg.sv | 23 ++
 rtl/wb_base_addr_lut.sv | 30 +++
 rtl/wb_addr_sequencer.sv | 137 +++++++++++++
 tb/tb_wb_addr_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_addr_sequencer_pkg.sv
// Shared sizes, opcode limits and FSM state type for the feature-map write-back sequencer.
package wb_addr_sequencer_pkg;

  localparam int FMAP_WORDS = 4096;
  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 16;
  localparam int OPC_W      = 6;
  localparam int PIX_W      = $clog2(FMAP_WORDS);
  localparam int IDX_W      = ADDR_W - PIX_W;

  localparam logic [OPC_W-1:0] SINGLE_CH_MAX = OPC_W'(15);
  localparam logic [OPC_W-1:0] LAST_OPC      = OPC_W'(31);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WR0,
    WR1,
    WR2,
    DONE
  } stateT;

endpackage

// File: rtl/wb_base_addr_lut.sv
// Maps a layer opcode to the base word address of each output channel's feature map.
module wb_base_addr_lut
  import wb_addr_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] base0,
  output logic [ADDR_W-1:0] base1,
  output logic [ADDR_W-1:0] base2,
  output logic              valid,
  output logic              threeCh
);

  logic [IDX_W-1:0] idx0;

  // Three-channel layers start at 3*opcode-29; the sum form keeps 3*opcode inside IDX_W bits.
  always_comb begin
    valid   = (opcode <= LAST_OPC);
    threeCh = valid && (opcode > SINGLE_CH_MAX);
    if (threeCh) begin
      idx0 = ({1'b0, opcode} + {opcode, 1'b0}) - IDX_W'(29);
    end else begin
      idx0 = IDX_W'(opcode) + IDX_W'(3);
    end
  end

  assign base0 = {idx0,              {PIX_W{1'b0}}};
  assign base1 = {idx0 + IDX_W'(1),  {PIX_W{1'b0}}};
  assign base2 = {idx0 + IDX_W'(2),  {PIX_W{1'b0}}};

endmodule

// File: rtl/wb_addr_sequencer.sv
// Layer write-back sequencer: takes one result pixel at a time and writes its 1 or 3
// channels into the feature memory at base(k)+pix, pixel by pixel over a 64x64 map.
module wb_addr_sequencer
  import wb_addr_sequencer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [OPC_W-1:0]  i_opcode,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  input  logic              i_res_valid,
  output logic              o_res_ready,
  input  logic [DATA_W-1:0] i_res_data0,
  input  logic [DATA_W-1:0] i_res_data1,
  input  logic [DATA_W-1:0] i_res_data2,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready
);

  stateT             state;
  logic [PIX_W-1:0]  pix;
  logic [DATA_W-1:0] hold1;
  logic [DATA_W-1:0] hold2;
  logic [ADDR_W-1:0] base0Q;
  logic [ADDR_W-1:0] base1Q;
  logic [ADDR_W-1:0] base2Q;
  logic              threeChQ;

  logic [ADDR_W-1:0] lutBase0;
  logic [ADDR_W-1:0] lutBase1;
  logic [ADDR_W-1:0] lutBase2;
  logic              lutValid;
  logic              lutThreeCh;

  logic [ADDR_W-1:0] pixExt;
  logic              endPix;
  logic              lastPix;

  wb_base_addr_lut uLut (
    .opcode  (i_opcode),
    .base0   (lutBase0),
    .base1   (lutBase1),
    .base2   (lutBase2),
    .valid   (lutValid),
    .threeCh (lutThreeCh)
  );

  assign pixExt  = ADDR_W'(pix);
  assign lastPix = (pix == PIX_W'(FMAP_WORDS - 1));
  assign endPix  = i_mem_ready && (((state == WR0) && !threeChQ) || (state == WR2));

  // Channel 0 goes straight into o_mem_wdata on capture, so only channels 1 and 2 need holding.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      pix         <= '0;
      hold1       <= '0;
      hold2       <= '0;
      base0Q      <= '0;
      base1Q      <= '0;
      base2Q      <= '0;
      threeChQ    <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_res_ready <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (lutValid) begin
              base0Q      <= lutBase0;
              base1Q      <= lutBase1;
              base2Q      <= lutBase2;
              threeChQ    <= lutThreeCh;
              pix         <= '0;
              o_busy      <= 1'b1;
              o_res_ready <= 1'b1;
              state       <= ACCEPT;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        ACCEPT: begin
          if (i_res_valid && o_res_ready) begin
            hold1       <= i_res_data1;
            hold2       <= i_res_data2;
            o_res_ready <= 1'b0;
            o_mem_we    <= 1'b1;
            o_mem_addr  <= base0Q + pixExt;
            o_mem_wdata <= i_res_data0;
            state       <= WR0;
          end
        end
        WR0, WR1, WR2: begin
          if (endPix) begin
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            pix         <= pix + PIX_W'(1);
            if (lastPix) begin
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= DONE;
            end else begin
              o_res_ready <= 1'b1;
              state       <= ACCEPT;
            end
          end else if (i_mem_ready) begin
            if (state == WR0) begin
              o_mem_addr  <= base1Q + pixExt;
              o_mem_wdata <= hold1;
              state       <= WR1;
            end else begin
              o_mem_addr  <= base2Q + pixExt;
              o_mem_wdata <= hold2;
              state       <= WR2;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_addr_sequencer.sv
// Scoreboard bench for wb_addr_sequencer: a pixel-level reference model queues expected
// writes on each accepted result pixel and a monitor pops them on each accepted memory write.
module tb_wb_addr_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [5:0]  i_opcode = '0;
  logic        i_res_valid = 1'b0;
  logic [15:0] i_res_data0 = '0;
  logic [15:0] i_res_data1 = '0;
  logic [15:0] i_res_data2 = '0;
  logic        i_mem_ready = 1'b0;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_res_ready;
  logic        o_mem_we;
  logic [18:0] o_mem_addr;
  logic [15:0] o_mem_wdata;

  wb_addr_sequencer dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_opcode    (i_opcode),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .i_res_valid (i_res_valid),
    .o_res_ready (o_res_ready),
    .i_res_data0 (i_res_data0),
    .i_res_data1 (i_res_data1),
    .i_res_data2 (i_res_data2),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ready (i_mem_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [18:0] addr;
    logic [15:0] data;
  } wrT;

  wrT expQ[$];
  wrT pushE;
  wrT popE;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int validPct = 100;
  int readyPct = 100;
  int stallReq = 0;

  int curOp = 0;
  int modelPix = 0;
  bit modelActive = 1'b0;

  int doneCount = 0;
  int errCount = 0;
  int doneCyc = 0;
  int errCyc = 0;
  int startCyc = 0;
  int wrCount = 0;
  int stallHolds = 0;
  int wrCyc[8];
  logic [18:0] firstAddr = '0;
  logic [18:0] lastAddr = '0;

  bit          prevStall = 1'b0;
  logic [18:0] prevAddr = '0;
  logic [15:0] prevData = '0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Word address of channel ch of the map written by opcode op, straight from the index rules.
  function automatic int refBase(input int op, input int ch);
    int idx;
    if (op <= 15) idx = op + 3;
    else          idx = 3 * op - 29 + ch;
    return idx * 4096;
  endfunction

  always @(posedge i_clk) cyc <= cyc + 1;

  // Input driver: random data every cycle, valid/ready throttled by percentages, optional stall.
  always @(posedge i_clk) begin
    #1;
    if (stallReq > 0 && o_mem_we) begin
      i_mem_ready = 1'b0;
      stallReq--;
    end else begin
      i_mem_ready = ($urandom_range(1, 100) <= readyPct);
    end
    i_res_valid = ($urandom_range(1, 100) <= validPct);
    i_res_data0 = 16'($urandom);
    i_res_data1 = 16'($urandom);
    i_res_data2 = 16'($urandom);
  end

  // Monitor: reference model on pixel handshakes, scoreboard pop on write handshakes.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        stallHolds++;
        checkOutput("stall_hold_we", o_mem_we, 1);
        checkOutput("stall_hold_addr", o_mem_addr, prevAddr);
        checkOutput("stall_hold_data", o_mem_wdata, prevData);
      end
      if (o_res_ready && i_res_valid) begin
        checkOutput("accept_in_layer", modelActive, 1);
        if (modelActive) begin
          for (int ch = 0; ch < ((curOp > 15) ? 3 : 1); ch++) begin
            pushE.addr = 19'(refBase(curOp, ch) + modelPix);
            pushE.data = (ch == 0) ? i_res_data0 : (ch == 1) ? i_res_data1 : i_res_data2;
            expQ.push_back(pushE);
          end
          modelPix++;
          if (modelPix == 4096) modelActive = 1'b0;
        end
      end
      if (o_mem_we && i_mem_ready) begin
        checkOutput("write_expected", expQ.size() > 0, 1);
        if (expQ.size() > 0) begin
          popE = expQ.pop_front();
          checkOutput("wr_addr", o_mem_addr, popE.addr);
          checkOutput("wr_data", o_mem_wdata, popE.data);
        end
        if (wrCount < 8) wrCyc[wrCount] = cyc;
        if (wrCount == 0) firstAddr = o_mem_addr;
        lastAddr = o_mem_addr;
        wrCount++;
      end
      if (o_done) begin
        doneCount++;
        doneCyc = cyc;
      end
      if (o_err) begin
        errCount++;
        errCyc = cyc;
      end
      prevStall = o_mem_we && !i_mem_ready;
      prevAddr  = o_mem_addr;
      prevData  = o_mem_wdata;
    end
  end

  task automatic clearStats();
    wrCount    = 0;
    doneCount  = 0;
    errCount   = 0;
    stallHolds = 0;
    for (int i = 0; i < 8; i++) wrCyc[i] = 0;
  endtask

  task automatic applyStimulus(input int op, input bit expectAccept);
    @(posedge i_clk);
    #2;
    i_opcode = 6'(op);
    i_start  = 1'b1;
    startCyc = cyc;
    if (expectAccept) begin
      curOp       = op;
      modelPix    = 0;
      modelActive = 1'b1;
    end
    @(posedge i_clk);
    #2;
    i_start = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_done"}, o_done, 0);
    checkOutput({tag, "_err"}, o_err, 0);
    checkOutput({tag, "_ready"}, o_res_ready, 0);
    checkOutput({tag, "_we"}, o_mem_we, 0);
    checkOutput({tag, "_addr"}, o_mem_addr, 0);
    checkOutput({tag, "_wdata"}, o_mem_wdata, 0);
  endtask

  task automatic pulseReset(input string tag);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    checkResetOutputs(tag);
    expQ.delete();
    modelActive = 1'b0;
    stallReq    = 0;
    repeat (2) @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
  endtask

  task automatic waitDone(input int bound);
    int n = 0;
    int d = doneCount;
    while (doneCount == d && n < bound) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput("done_seen", doneCount > d, 1);
    repeat (3) @(negedge i_clk);
  endtask

  task automatic waitPix(input int target, input int bound);
    int n = 0;
    while (modelPix < target && n < bound) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput("pix_reached", modelPix >= target, 1);
  endtask

  task automatic waitWrites(input int target, input int bound);
    int n = 0;
    while (wrCount < target && n < bound) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput("writes_reached", wrCount >= target, 1);
  endtask

  initial begin
    int op;
    repeat (3) @(posedge i_clk);
    #1;
    checkResetOutputs("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    $display("[TB] opcode 0, no backpressure");
    clearStats();
    validPct = 100;
    readyPct = 100;
    applyStimulus(0, 1);
    waitDone(20000);
    checkOutput("op0_latency", doneCyc - startCyc, 8193);
    checkOutput("op0_writes", wrCount, 4096);
    checkOutput("op0_first_addr", firstAddr, 12288);
    checkOutput("op0_last_addr", lastAddr, 16383);
    checkOutput("op0_done_once", doneCount, 1);
    checkOutput("op0_queue_empty", expQ.size(), 0);
    checkOutput("op0_busy_low", o_busy, 0);

    $display("[TB] opcode 16, first pixel timing");
    clearStats();
    applyStimulus(16, 1);
    waitWrites(4, 200);
    checkOutput("op16_first_addr", firstAddr, 77824);
    checkOutput("op16_wr1_gap", wrCyc[1] - wrCyc[0], 1);
    checkOutput("op16_wr2_gap", wrCyc[2] - wrCyc[1], 1);
    checkOutput("op16_pixel_period", wrCyc[3] - wrCyc[0], 4);
    pulseReset("op16_reset");

    $display("[TB] opcode 31, full three-channel layer");
    clearStats();
    applyStimulus(31, 1);
    waitDone(40000);
    checkOutput("op31_latency", doneCyc - startCyc, 16385);
    checkOutput("op31_writes", wrCount, 12288);
    checkOutput("op31_last_addr", lastAddr, 274431);
    checkOutput("op31_done_once", doneCount, 1);
    checkOutput("op31_queue_empty", expQ.size(), 0);

    $display("[TB] opcode 5, stall and ignored starts");
    clearStats();
    applyStimulus(5, 1);
    waitWrites(3, 200);
    stallReq = 3;
    repeat (12) @(negedge i_clk);
    checkOutput("op5_stall_cycles", stallHolds, 3);
    applyStimulus(40, 0);
    applyStimulus(20, 0);
    repeat (3) @(negedge i_clk);
    checkOutput("op5_busy_start_no_err", errCount, 0);
    validPct = 70;
    readyPct = 70;
    waitDone(60000);
    checkOutput("op5_writes", wrCount, 4096);
    checkOutput("op5_last_addr", lastAddr, 36863);
    checkOutput("op5_done_once", doneCount, 1);
    checkOutput("op5_queue_empty", expQ.size(), 0);

    $display("[TB] invalid opcodes");
    for (int k = 0; k < 2; k++) begin
      clearStats();
      op = (k == 0) ? 40 : int'($urandom_range(32, 63));
      applyStimulus(op, 0);
      repeat (6) @(negedge i_clk);
      checkOutput("inv_err_once", errCount, 1);
      checkOutput("inv_err_latency", errCyc - startCyc, 1);
      checkOutput("inv_no_writes", wrCount, 0);
      checkOutput("inv_no_done", doneCount, 0);
      checkOutput("inv_busy_low", o_busy, 0);
      checkOutput("inv_err_cleared", o_err, 0);
    end

    $display("[TB] opcode 20, reset mid-layer then restart");
    clearStats();
    validPct = 80;
    readyPct = 80;
    applyStimulus(20, 1);
    waitPix(100, 5000);
    pulseReset("op20_reset");
    repeat (10) @(negedge i_clk);
    checkOutput("op20_no_done", doneCount, 0);
    clearStats();
    applyStimulus(20, 1);
    waitWrites(6, 500);
    checkOutput("op20_restart_addr", firstAddr, 126976);
    pulseReset("op20_reset2");

    $display("[TB] random opcode, random backpressure");
    clearStats();
    op = int'($urandom_range(0, 31));
    validPct = int'($urandom_range(50, 100));
    readyPct = int'($urandom_range(50, 100));
    applyStimulus(op, 1);
    waitPix(40, 2000);
    repeat (20) @(negedge i_clk);
    checkOutput("rand_first_addr", firstAddr, refBase(op, 0));
    pulseReset("rand_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
